freq_div_multi: RTL and testbench
=================================

FREQ_DIV_MULTI -- requirements
Module: freq_div_multi

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter CH, default 4, number of independent output channels (1..16).
REQ-003 Parameter CNT_W, default 32, half-period counter and divider width.
REQ-004 Parameter DEF_HZ, default 4, reset output frequency of every channel; reset half-period H0 = CLK_HZ/(2*DEF_HZ), truncated.
REQ-005 iCLK  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 iRST_N  in  1  reset, asynchronous, active-low.
REQ-007 iEN  in  CH  per-channel run enable, level.
REQ-008 iWR  in  1  divider-write strobe, one cycle.
REQ-009 iWR_CH  in  4  target channel index for the write.
REQ-010 iWR_DIV  in  CNT_W  new half-period H, in iCLK cycles.
REQ-011 oSIG  out  CH  per-channel square wave, 50% duty, period 2*H cycles.
REQ-012 oTICK  out  CH  one-cycle pulse on each rising edge of the corresponding oSIG bit.
REQ-013 oERR  out  1  one-cycle pulse flagging a rejected write.

Function
REQ-014 Each channel SHALL hold an active half-period A, a pending half-period P, and a counter C.
REQ-015 While iEN[n]=1, C[n] SHALL increment each cycle; at C=A-1, C SHALL return to 0 and oSIG[n] SHALL toggle in the next cycle.
REQ-016 With A=1, oSIG[n] SHALL toggle every cycle, giving iCLK/2.
REQ-017 oTICK[n] SHALL be 1 for exactly the cycle in which oSIG[n] changes from 0 to 1.
REQ-018 While iEN[n]=0, C[n]=0, oSIG[n]=0 and oTICK[n]=0; A[n]=P[n] immediately.
REQ-019 On an iEN[n] 0->1 transition, the first oSIG[n] rise SHALL occur A cycles after the first cycle in which iEN[n]=1.
REQ-020 A valid write (iWR=1, iWR_CH<CH, iWR_DIV!=0) SHALL load P[iWR_CH]; A SHALL take P at the next wrap of C (glitch-free retune).
REQ-021 A write in the same cycle as a wrap on that channel SHALL load both A and P with iWR_DIV.
REQ-022 Multiple writes to one channel before its wrap: the last write wins.
REQ-023 A write with iWR_CH>=CH or iWR_DIV=0 SHALL change no state and SHALL pulse oERR in the next cycle.
REQ-024 Channels SHALL be fully independent; simultaneous wraps on several channels SHALL all be honoured.

Reset
REQ-025 While iRST_N=0: oSIG=0, oTICK=0, oERR=0, all C=0, and all A=P=H0, asynchronously.
REQ-026 Reset deassertion mid-period SHALL restart every enabled channel per REQ-019.

Configuration
REQ-027 Macro FDIV_PHASE_SYNC_EN, when defined, SHALL add input iSYNC (1 bit): when iSYNC=1, all C=0 and all oSIG=0 in the next cycle, so that the channels are phase-aligned; iSYNC SHALL take priority over wrap and over A update.
REQ-028 When FDIV_PHASE_SYNC_EN is undefined, iSYNC SHALL be absent and the behaviour SHALL otherwise be identical.

Structure
REQ-029 Package fdiv_pkg SHALL hold the CNT_W default, the channel-index width (4), and the function computing H0 from CLK_HZ and DEF_HZ.
REQ-030 Per-channel logic (C, A, P, oSIG, oTICK) SHALL be the sub-module fdiv_channel, instantiated CH times by a generate loop; write decode and oERR stay in the top level.

Verification (bench: CLK_HZ=800, DEF_HZ=4, so H0=100; CH=4; 20 ns iCLK)
REQ-031 Reset release, iEN=4'hF -> all oSIG rise at cycle 100 and fall at cycle 200; oTICK is one cycle wide, once per 200 cycles.
REQ-032 Write ch1 H=10 at cycle 50 -> ch1 keeps H=100 until its wrap at cycle 99, then toggles every 10 cycles; ch0, ch2 and ch3 are unchanged.
REQ-033 Write iWR_CH=5, then iWR_DIV=0 on ch0 -> oERR pulses once for each write; no channel timing changes.
REQ-034 Write ch2 H=1 -> after the wrap, oSIG[2] toggles every cycle; drop iEN[2] -> oSIG[2]=0 the next cycle; re-enable -> the first rise comes 1 cycle later.
REQ-035 Assert iRST_N=0 asynchronously mid-period -> outputs go to 0 without waiting for an iCLK edge; after release, dividers are back at 100.
REQ-036 With FDIV_PHASE_SYNC_EN defined: ch0 H=30, ch1 H=50, pulse iSYNC -> both oSIG are 0 and both rise exactly 30 and 50 cycles after the sync.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared constants and the reset half-period helper for the multi-channel frequency divider.
package fdiv_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned CH_IDX_W  = 4;

  // Reset half-period in clock cycles, truncated.
  function automatic int unsigned calc_h0(input int unsigned clk_hz, input int unsigned def_hz);
    return clk_hz / (2 * def_hz);
  endfunction

endpackage

// File: rtl/fdiv_channel.sv
// One divider channel: counter C, active half-period A, pending half-period P,
// registered square-wave output and rising-edge tick.
module fdiv_channel
  import fdiv_pkg::*;
#(
  parameter int unsigned      CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] H0    = CNT_W'(calc_h0(50000000, 4))
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iEN,
  input  logic             iSYNC,
  input  logic             iWR,
  input  logic [CNT_W-1:0] iWR_DIV,
  output logic             oSIG,
  output logic             oTICK
);

  logic [CNT_W-1:0] r_c;
  logic [CNT_W-1:0] r_a;
  logic [CNT_W-1:0] r_p;
  logic             r_sig;
  logic             r_tick;
  logic             w_wrap;
  logic [CNT_W-1:0] w_next_a;

  assign w_wrap   = (r_c == (r_a - CNT_W'(1)));
  // A write landing on the update cycle goes straight into A as well as P.
  assign w_next_a = iWR ? iWR_DIV : r_p;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_c    <= '0;
      r_a    <= H0;
      r_p    <= H0;
      r_sig  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (iWR) begin
        r_p <= iWR_DIV;
      end
      r_tick <= 1'b0;
      if (iSYNC) begin
        r_c   <= '0;
        r_sig <= 1'b0;
      end else if (!iEN) begin
        r_c   <= '0;
        r_sig <= 1'b0;
        r_a   <= w_next_a;
      end else if (w_wrap) begin
        r_c    <= '0;
        r_sig  <= ~r_sig;
        r_tick <= ~r_sig;
        r_a    <= w_next_a;
      end else begin
        r_c <= r_c + CNT_W'(1);
      end
    end
  end

  assign oSIG  = r_sig;
  assign oTICK = r_tick;

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel programmable square-wave divider with glitch-free retune and write decode.
// Optional FDIV_PHASE_SYNC_EN adds iSYNC, which zeroes every channel for phase alignment.
module freq_div_multi
  import fdiv_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CH     = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DEF_HZ = 4
) (
  input  logic                iCLK,
  input  logic                iRST_N,
`ifdef FDIV_PHASE_SYNC_EN
  input  logic                iSYNC,
`endif
  input  logic [CH-1:0]       iEN,
  input  logic                iWR,
  input  logic [CH_IDX_W-1:0] iWR_CH,
  input  logic [CNT_W-1:0]    iWR_DIV,
  output logic [CH-1:0]       oSIG,
  output logic [CH-1:0]       oTICK,
  output logic                oERR
);

  localparam logic [CNT_W-1:0] H0 = CNT_W'(calc_h0(CLK_HZ, DEF_HZ));

  logic w_wr_ok;
  logic w_sync;
  logic r_err;

`ifdef FDIV_PHASE_SYNC_EN
  assign w_sync = iSYNC;
`else
  assign w_sync = 1'b0;
`endif

  assign w_wr_ok = iWR && (32'(iWR_CH) < CH) && (iWR_DIV != '0);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_err <= 1'b0;
    end else begin
      r_err <= iWR && !w_wr_ok;
    end
  end

  assign oERR = r_err;

  for (genvar g = 0; g < int'(CH); g++) begin : g_ch
    logic w_wr_sel;
    assign w_wr_sel = w_wr_ok && (iWR_CH == CH_IDX_W'(g));

    fdiv_channel #(
      .CNT_W (CNT_W),
      .H0    (H0)
    ) u_ch (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .iEN     (iEN[g]),
      .iSYNC   (w_sync),
      .iWR     (w_wr_sel),
      .iWR_DIV (iWR_DIV),
      .oSIG    (oSIG[g]),
      .oTICK   (oTICK[g])
    );
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed, table-driven bench for freq_div_multi with CLK_HZ=800, DEF_HZ=4 (H0=100), CH=4.
// Cycle k is observed 1 ns after the k-th rising edge following reset release.
module tb_freq_div_multi;

  typedef struct {
    int          cyc;
    logic [3:0]  en;
    logic        wr;
    logic [3:0]  ch;
    logic [31:0] div;
    logic [3:0]  sig;
    logic [3:0]  tick;
    logic        err;
  } vec_t;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [3:0]  iEN = 4'hF;
  logic        iWR = 1'b0;
  logic [3:0]  iWR_CH = '0;
  logic [31:0] iWR_DIV = '0;
`ifdef FDIV_PHASE_SYNC_EN
  logic        iSYNC = 1'b0;
`endif
  logic [3:0]  oSIG;
  logic [3:0]  oTICK;
  logic        oERR;

  int   cyc;
  int   n_vec;
  int   n_bad;
  vec_t tbl[$];

  freq_div_multi #(
    .CLK_HZ (800),
    .CH     (4),
    .CNT_W  (32),
    .DEF_HZ (4)
  ) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
`ifdef FDIV_PHASE_SYNC_EN
    .iSYNC   (iSYNC),
`endif
    .iEN     (iEN),
    .iWR     (iWR),
    .iWR_CH  (iWR_CH),
    .iWR_DIV (iWR_DIV),
    .oSIG    (oSIG),
    .oTICK   (oTICK),
    .oERR    (oERR)
  );

  always #10 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
    iWR     = 1'b0;
    iWR_CH  = '0;
    iWR_DIV = '0;
`ifdef FDIV_PHASE_SYNC_EN
    iSYNC   = 1'b0;
`endif
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic check(input string name, input logic [3:0] s, input logic [3:0] t,
                       input logic e);
    n_vec++;
    if (oSIG !== s || oTICK !== t || oERR !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: sig/tick/err got %b/%b/%b want %b/%b/%b",
               name, cyc, oSIG, oTICK, oERR, s, t, e);
    end
  endtask

  function automatic vec_t v(input int c, input logic [3:0] en, input logic wr,
                             input logic [3:0] ch, input logic [31:0] d,
                             input logic [3:0] s, input logic [3:0] t, input logic e);
    vec_t r;
    r.cyc = c; r.en = en; r.wr = wr; r.ch = ch; r.div = d;
    r.sig = s; r.tick = t; r.err = e;
    return r;
  endfunction

  initial begin
    //              cyc  en    wr  ch  div  sig      tick     err
    tbl.push_back(v(1,   4'hF, 0,  0,  0,   4'b0000, 4'b0000, 0));
    tbl.push_back(v(50,  4'hF, 1,  1,  10,  4'b0000, 4'b0000, 0));
    tbl.push_back(v(99,  4'hF, 0,  0,  0,   4'b0000, 4'b0000, 0));
    tbl.push_back(v(100, 4'hF, 0,  0,  0,   4'b1111, 4'b1111, 0));
    tbl.push_back(v(101, 4'hF, 0,  0,  0,   4'b1111, 4'b0000, 0));
    tbl.push_back(v(109, 4'hF, 0,  0,  0,   4'b1111, 4'b0000, 0));
    tbl.push_back(v(110, 4'hF, 0,  0,  0,   4'b1101, 4'b0000, 0));
    tbl.push_back(v(120, 4'hF, 0,  0,  0,   4'b1111, 4'b0010, 0));
    tbl.push_back(v(121, 4'hF, 0,  0,  0,   4'b1111, 4'b0000, 0));
    tbl.push_back(v(130, 4'hF, 1,  5,  7,   4'b1101, 4'b0000, 0));
    tbl.push_back(v(131, 4'hF, 1,  0,  0,   4'b1101, 4'b0000, 1));
    tbl.push_back(v(132, 4'hF, 0,  0,  0,   4'b1101, 4'b0000, 1));
    tbl.push_back(v(133, 4'hF, 0,  0,  0,   4'b1101, 4'b0000, 0));
    tbl.push_back(v(140, 4'hF, 0,  0,  0,   4'b1111, 4'b0010, 0));
    tbl.push_back(v(199, 4'hF, 0,  0,  0,   4'b1101, 4'b0000, 0));
    tbl.push_back(v(200, 4'hF, 0,  0,  0,   4'b0010, 4'b0010, 0));
    tbl.push_back(v(300, 4'hF, 0,  0,  0,   4'b1111, 4'b1111, 0));
    tbl.push_back(v(301, 4'hF, 0,  0,  0,   4'b1111, 4'b0000, 0));
    tbl.push_back(v(310, 4'hF, 1,  2,  1,   4'b1101, 4'b0000, 0));
    tbl.push_back(v(399, 4'hF, 0,  0,  0,   4'b1101, 4'b0000, 0));
    tbl.push_back(v(400, 4'hF, 0,  0,  0,   4'b0010, 4'b0010, 0));
    tbl.push_back(v(401, 4'hF, 0,  0,  0,   4'b0110, 4'b0100, 0));
    tbl.push_back(v(402, 4'hF, 0,  0,  0,   4'b0010, 4'b0000, 0));
    tbl.push_back(v(403, 4'hF, 0,  0,  0,   4'b0110, 4'b0100, 0));
    tbl.push_back(v(405, 4'hB, 0,  0,  0,   4'b0110, 4'b0100, 0));
    tbl.push_back(v(406, 4'hB, 0,  0,  0,   4'b0010, 4'b0000, 0));
    tbl.push_back(v(408, 4'hB, 0,  0,  0,   4'b0010, 4'b0000, 0));
    tbl.push_back(v(410, 4'hF, 0,  0,  0,   4'b0000, 4'b0000, 0));
    tbl.push_back(v(411, 4'hF, 0,  0,  0,   4'b0100, 4'b0100, 0));
    tbl.push_back(v(412, 4'hF, 0,  0,  0,   4'b0000, 4'b0000, 0));
    tbl.push_back(v(413, 4'hF, 0,  0,  0,   4'b0100, 4'b0100, 0));

    cyc   = 0;
    n_vec = 0;
    n_bad = 0;

    repeat (3) @(posedge iCLK);
    #1;
    check("reset_state", 4'b0000, 4'b0000, 1'b0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    cyc    = 0;

    foreach (tbl[i]) begin
      run_to(tbl[i].cyc);
      check($sformatf("vec%0d", i), tbl[i].sig, tbl[i].tick, tbl[i].err);
      iEN = tbl[i].en;
      if (tbl[i].wr) begin
        iWR     = 1'b1;
        iWR_CH  = tbl[i].ch;
        iWR_DIV = tbl[i].div;
      end
    end

    // Asynchronous reset mid-period, then dividers must be back at H0.
    run_to(526);
    check("pre_async_reset", 4'b1011, 4'b0000, 1'b0);
    #5;
    iRST_N = 1'b0;
    #1;
    check("async_reset", 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
    cyc    = 0;
    run_to(99);
    check("rerun_c99", 4'b0000, 4'b0000, 1'b0);
    run_to(100);
    check("rerun_c100", 4'b1111, 4'b1111, 1'b0);
    run_to(200);
    check("rerun_c200", 4'b0000, 4'b0000, 1'b0);

`ifdef FDIV_PHASE_SYNC_EN
    begin
      int s;
      iEN = 4'h0;
      step();
      iWR = 1'b1; iWR_CH = 4'd0; iWR_DIV = 32'd30;
      step();
      iWR = 1'b1; iWR_CH = 4'd1; iWR_DIV = 32'd50;
      step();
      iEN = 4'hF;
      repeat (40) step();
      iSYNC = 1'b1;
      s = cyc;
      step();
      check("sync_zero", 4'b0000, 4'b0000, 1'b0);
      run_to(s + 30);
      check("sync_ch0_pre", 4'b0000, 4'b0000, 1'b0);
      run_to(s + 31);
      check("sync_ch0_rise", 4'b0001, 4'b0001, 1'b0);
      run_to(s + 50);
      check("sync_ch1_pre", 4'b0001, 4'b0000, 1'b0);
      run_to(s + 51);
      check("sync_ch1_rise", 4'b0011, 4'b0010, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
